imem_arbiter: RTL
=================

# imem_arbiter

Two-requester arbiter for the single-port 256 x 16 program memory. It shares the memory between the processor's instruction-fetch port and the program loader/debug port, using round-robin arbitration with a bounded loader burst lock. Memory access is issued in the grant cycle, and read data is routed back to the owning requester one cycle later. The block sits between the core, the loader and the synchronous program RAM.

## Interface
Parameters:
- AW, 8, address width (256 words)
- DW, 16, data width
- MAX_BURST, 8, max consecutive loader grants under l_lock while f_req is pending (range 1..255)

Ports:
- clk  in  1  clock. One clock; all state updates on its rising edge.
- rst  in  1  reset. Synchronous, active-high.
- f_req  in  1  fetch request. Level; held until granted.
- f_addr  in  AW  fetch address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DW  fetch read data
- l_req  in  1  loader request. Level; held until granted.
- l_we  in  1  loader write (1) / read (0)
- l_lock  in  1  loader requests back-to-back grants
- l_addr  in  AW  loader address
- l_wdata  in  DW  loader write data
- l_gnt  out  1  loader granted this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DW  loader read data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data. Valid one cycle after mem_en with mem_we=0.
- stall  out  1  f_req high and f_gnt low (core holds its pc)

## Operation
- State:
  - last_owner (1 bit): 0 = fetch, 1 = loader.
  - burst_cnt (8 bits).
  - rd_owner (2 bits): 00 none, 01 fetch, 10 loader.
- Grant decision is combinational from current requests and state; at most one grant per cycle.
  - Only one requester high: that requester is granted.
  - Both high, l_lock=0: grant the requester that is not last_owner.
  - Both high, l_lock=1, last_owner=loader, burst_cnt < MAX_BURST: grant loader.
  - Both high, l_lock=1, burst_cnt >= MAX_BURST: grant fetch (forced yield).
  - Both high, l_lock=1, last_owner=fetch: grant loader.
- On any grant:
  - mem_en=1.
  - mem_addr/mem_wdata/mem_we are taken from the winner. Fetch is always a read.
  - last_owner is updated.
- burst_cnt:
  - Increments (saturating at 255) on each loader grant with l_lock=1.
  - Clears on any fetch grant, or when l_lock=0.
- Reads: rd_owner is registered at the grant edge. The next cycle asserts the matching *_rvalid, with *_rdata = mem_rdata.
- Writes: l_gnt is the completion. No l_rvalid follows a write.
- Non-owner *_rdata is held at 0.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Address wrap: none. The full AW-bit address is passed through unchanged.

## Timing
- Reset (rst high at a rising edge):
  - last_owner=1, so fetch wins the first contention.
  - burst_cnt=0, rd_owner=00.
- While rst is high, all outputs are forced to 0: gnts, rvalids, rdata, mem_*, stall.
- A read granted in the cycle before rst asserts is discarded; its rvalid never appears.
- Requests held across rst deassertion are arbitrated in the first cycle with rst low.
- Latency:
  - Grant: 0 cycles. The gnt is asserted in the same cycle as the qualifying req.
  - Read data: 1 cycle after the grant.
  - Back-to-back reads are allowed each cycle. Throughput is 1 access per cycle.
- Requesters must keep addr/we/wdata stable while req=1 and gnt=0. A request is consumed in its grant cycle. To issue another access, keep req high with new operands from the next cycle.
- stall equals f_req & ~f_gnt, combinational.
- Simultaneous loader write and fetch read of the same address: order follows the grant. The fetch sees the new data only if the loader write was granted in an earlier cycle.

## Test plan
- Reset then f_req=1, addr=0x00..0x03 across 4 cycles, mem holding 0xC105,0xC20A,0x1003,0x1004:
  - f_gnt high in each cycle.
  - f_rvalid asserted 1 cycle later with matching data.
  - stall=0 throughout.
- f_req and l_req both held, l_lock=0, for 6 cycles:
  - Grants alternate F,L,F,L,F,L (fetch first after reset).
  - stall high exactly on loader cycles.
- l_lock=1, MAX_BURST=8, both requesting:
  - 8 loader grants, then 1 fetch grant, then 8 loader grants again.
  - burst_cnt returns to 0 after the fetch grant.
- Loader write 0xD07F to addr 0x10, then fetch read of 0x10 in the next cycle:
  - f_rdata = 0xD07F.
  - No l_rvalid after the write.
- Fetch read granted, rst asserted the next cycle:
  - f_rvalid stays 0 and all outputs are 0 during rst.
  - After release with both requests high, fetch is granted first.
- Loader read of addr 0xFF:
  - mem_addr=0xFF.
  - l_rvalid with RAM data 1 cycle later.
  - f_rvalid stays 0.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port 256 x 16 program RAM between the
// instruction-fetch port and the loader/debug port. Round-robin arbitration
// with a bounded loader burst lock; the RAM is accessed in the grant cycle
// and read data is steered back to its owner one cycle later.
module imem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  typedef enum logic [1:0] {
    RD_NONE  = 2'b00,
    RD_FETCH = 2'b01,
    RD_LOAD  = 2'b10
  } rd_owner_t;

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  logic      r_last_owner;   // 0 = fetch, 1 = loader
  logic [7:0] r_burst_cnt;
  rd_owner_t r_rd_owner_p1;  // owner of the read issued in the previous cycle

  logic w_f_win;
  logic w_l_win;

  // Grant decision: combinational from requests and arbitration state.
  always_comb begin
    w_f_win = 1'b0;
    w_l_win = 1'b0;
    if (f_req && !l_req) begin
      w_f_win = 1'b1;
    end else if (l_req && !f_req) begin
      w_l_win = 1'b1;
    end else if (f_req && l_req) begin
      if (!l_lock) begin
        // Plain round-robin: the requester that did not win last time.
        if (r_last_owner) w_f_win = 1'b1;
        else              w_l_win = 1'b1;
      end else if (r_burst_cnt >= BURST_LIM) begin
        // Locked burst has used its budget: fetch gets a forced slot.
        w_f_win = 1'b1;
      end else begin
        w_l_win = 1'b1;
      end
    end
    if (rst) begin
      w_f_win = 1'b0;
      w_l_win = 1'b0;
    end
  end

  assign f_gnt     = w_f_win;
  assign l_gnt     = w_l_win;
  assign stall     = f_req & ~w_f_win & ~rst;
  assign mem_en    = w_f_win | w_l_win;
  assign mem_we    = w_l_win & l_we;
  assign mem_addr  = w_f_win ? f_addr : (w_l_win ? l_addr : '0);
  assign mem_wdata = w_l_win ? l_wdata : '0;

  assign f_rvalid  = ~rst & (r_rd_owner_p1 == RD_FETCH);
  assign l_rvalid  = ~rst & (r_rd_owner_p1 == RD_LOAD);
  assign f_rdata   = f_rvalid ? mem_rdata : '0;
  assign l_rdata   = l_rvalid ? mem_rdata : '0;

  // Arbitration state and read-return owner, updated at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner  <= 1'b1;
      r_burst_cnt   <= 8'd0;
      r_rd_owner_p1 <= RD_NONE;
    end else begin
      if (w_f_win)      r_last_owner <= 1'b0;
      else if (w_l_win) r_last_owner <= 1'b1;

      if (w_l_win && l_lock) begin
        if (r_burst_cnt != 8'hFF) r_burst_cnt <= r_burst_cnt + 8'd1;
      end else if (w_f_win || !l_lock) begin
        r_burst_cnt <= 8'd0;
      end

      if (w_f_win)               r_rd_owner_p1 <= RD_FETCH;
      else if (w_l_win && !l_we) r_rd_owner_p1 <= RD_LOAD;
      else                       r_rd_owner_p1 <= RD_NONE;
    end
  end

endmodule
